// File: rtl/legv8_pkg.sv
// rtl/legv8_pkg.sv - LEGv8 opcodes, FSM states, ALU codes and XZR index helper
package legv8_pkg;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [5:0]  OP_B    = 6'b000101;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_HALT
  } state_t;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR} alu_op_t;

  typedef enum logic [2:0] {I_RTYPE, I_LDUR, I_STUR, I_CBZ, I_B} iclass_t;

  function automatic logic [4:0] xzr_index(input int reg_count);
    return 5'(reg_count - 1);
  endfunction

endpackage

// File: rtl/multicycle_register_file.sv
// rtl/multicycle_register_file.sv - two-read one-write register file with hardwired XZR
module multicycle_register_file
  import legv8_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int REG_COUNT  = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4:0]            read_addr_a,
  input  logic [4:0]            read_addr_b,
  output logic [DATA_WIDTH-1:0] read_data_a,
  output logic [DATA_WIDTH-1:0] read_data_b,
  input  logic                  write_en,
  input  logic [4:0]            write_addr,
  input  logic [DATA_WIDTH-1:0] write_data
);

  localparam logic [4:0] XZR = xzr_index(REG_COUNT);

  // XZR and anything above it has no storage
  logic [DATA_WIDTH-1:0] regs [REG_COUNT-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT - 1; i++) regs[i] <= '0;
    end else if (write_en && write_addr < XZR) begin
      regs[write_addr] <= write_data;
    end
  end

  assign read_data_a = (read_addr_a < XZR) ? regs[read_addr_a] : '0;
  assign read_data_b = (read_addr_b < XZR) ? regs[read_addr_b] : '0;

endmodule

// File: rtl/multicycle_cpu.sv
// rtl/multicycle_cpu.sv - multi-cycle LEGv8 core on one req/ready memory port
// Define MULTICYCLE_CPU_PERF_COUNTERS_EN to add cycle_count/instr_retired outputs.
module multicycle_cpu
  import legv8_pkg::*;
#(
  parameter int                    DATA_WIDTH = 64,
  parameter int                    REG_COUNT  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic [DATA_WIDTH-1:0] pc_out,
  output logic                  halted
`ifdef MULTICYCLE_CPU_PERF_COUNTERS_EN
  ,
  output logic [DATA_WIDTH-1:0] cycle_count,
  output logic [DATA_WIDTH-1:0] instr_retired
`endif
);

  state_t                state, next_state;
  iclass_t               iclass, dec_class;
  alu_op_t               alu_op, dec_alu;
  logic                  dec_valid, hs, rf_we;
  logic [31:0]           ir;
  logic [DATA_WIDTH-1:0] pc, pc_d, a, b, imm, alu_out, mdr;
  logic [DATA_WIDTH-1:0] rd_a, rd_b, dec_imm, alu_y, alu_result;
  logic [DATA_WIDTH-1:0] addr_d, wdata_d;
  logic                  req_d, we_d;

  assign hs     = mem_req && mem_ready;
  assign pc_out = pc;
  assign halted = (state == S_HALT);

  always_comb begin
    dec_valid = 1'b1;
    dec_class = I_RTYPE;
    dec_alu   = ALU_ADD;
    case (ir[31:21])
      OP_ADD:  dec_alu = ALU_ADD;
      OP_SUB:  dec_alu = ALU_SUB;
      OP_AND:  dec_alu = ALU_AND;
      OP_ORR:  dec_alu = ALU_ORR;
      OP_LDUR: dec_class = I_LDUR;
      OP_STUR: dec_class = I_STUR;
      default: begin
        if (ir[31:24] == OP_CBZ)     dec_class = I_CBZ;
        else if (ir[31:26] == OP_B)  dec_class = I_B;
        else                         dec_valid = 1'b0;
      end
    endcase
    case (dec_class)
      I_CBZ:   dec_imm = {{(DATA_WIDTH-21){ir[23]}}, ir[23:5], 2'b00};
      I_B:     dec_imm = {{(DATA_WIDTH-28){ir[25]}}, ir[25:0], 2'b00};
      default: dec_imm = {{(DATA_WIDTH-9){ir[20]}}, ir[20:12]};
    endcase
  end

  multicycle_register_file #(.DATA_WIDTH(DATA_WIDTH), .REG_COUNT(REG_COUNT)) u_rf (
    .clock       (clock),
    .reset       (reset),
    .read_addr_a (ir[9:5]),
    .read_addr_b ((dec_class == I_RTYPE) ? ir[20:16] : ir[4:0]),
    .read_data_a (rd_a),
    .read_data_b (rd_b),
    .write_en    (rf_we),
    .write_addr  (ir[4:0]),
    .write_data  ((iclass == I_LDUR) ? mdr : alu_out)
  );

  assign alu_y = (iclass == I_LDUR || iclass == I_STUR) ? imm : b;

  always_comb begin
    case (alu_op)
      ALU_SUB: alu_result = a - alu_y;
      ALU_AND: alu_result = a & alu_y;
      ALU_ORR: alu_result = a | alu_y;
      default: alu_result = a + alu_y;
    endcase
  end

  always_comb begin
    next_state = state;
    pc_d       = pc;
    rf_we      = 1'b0;
    req_d      = 1'b0;
    we_d       = 1'b0;
    addr_d     = '0;
    wdata_d    = '0;
    case (state)
      S_FETCH:  if (hs) next_state = S_DECODE;
      S_DECODE: next_state = dec_valid ? S_EXECUTE : S_HALT;
      S_EXECUTE: begin
        case (iclass)
          I_RTYPE:        next_state = S_WRITEBACK;
          I_LDUR, I_STUR: next_state = S_MEMORY;
          I_CBZ: begin
            next_state = S_FETCH;
            pc_d = (b == '0) ? pc + imm : pc + DATA_WIDTH'(4);
          end
          I_B: begin
            next_state = S_FETCH;
            pc_d = pc + imm;
          end
          default:        next_state = S_HALT;
        endcase
      end
      S_MEMORY: begin
        if (hs) begin
          if (iclass == I_STUR) begin
            next_state = S_FETCH;
            pc_d = pc + DATA_WIDTH'(4);
          end else begin
            next_state = S_WRITEBACK;
          end
        end
      end
      S_WRITEBACK: begin
        rf_we      = 1'b1;
        pc_d       = pc + DATA_WIDTH'(4);
        next_state = S_FETCH;
      end
      default: next_state = S_HALT;
    endcase
    // Bus outputs are registered from the state being entered
    case (next_state)
      S_FETCH: begin
        req_d  = 1'b1;
        addr_d = pc_d;
      end
      S_MEMORY: begin
        req_d   = 1'b1;
        we_d    = (iclass == I_STUR);
        addr_d  = (state == S_EXECUTE) ? alu_result : alu_out;
        wdata_d = (iclass == I_STUR) ? b : '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      ir        <= '0;
      a         <= '0;
      b         <= '0;
      imm       <= '0;
      alu_out   <= '0;
      mdr       <= '0;
      iclass    <= I_RTYPE;
      alu_op    <= ALU_ADD;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= next_state;
      pc        <= pc_d;
      mem_req   <= req_d;
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      if (state == S_FETCH && hs) ir <= mem_rdata[31:0];
      if (state == S_DECODE) begin
        a      <= rd_a;
        b      <= rd_b;
        imm    <= dec_imm;
        iclass <= dec_class;
        alu_op <= dec_alu;
      end
      if (state == S_EXECUTE) alu_out <= alu_result;
      if (state == S_MEMORY && hs) mdr <= mem_rdata;
    end
  end

`ifdef MULTICYCLE_CPU_PERF_COUNTERS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_count   <= '0;
      instr_retired <= '0;
    end else begin
      if (state != S_HALT) cycle_count <= cycle_count + DATA_WIDTH'(1);
      if (next_state == S_FETCH &&
          (state == S_EXECUTE || state == S_MEMORY || state == S_WRITEBACK))
        instr_retired <= instr_retired + DATA_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_cpu.sv
// tb/tb_multicycle_cpu.sv - ISA-level model and bus scoreboard for multicycle_cpu
module tb_multicycle_cpu;

  localparam logic [10:0] T_ADD  = 11'b10001011000;
  localparam logic [10:0] T_SUB  = 11'b11001011000;
  localparam logic [10:0] T_AND  = 11'b10001010000;
  localparam logic [10:0] T_ORR  = 11'b10101010000;
  localparam logic [10:0] T_LDUR = 11'b11111000010;
  localparam logic [10:0] T_STUR = 11'b11111000000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we, mem_ready, halted;
  logic [63:0] mem_addr, mem_wdata, mem_rdata, pc_out;
`ifdef MULTICYCLE_CPU_PERF_COUNTERS_EN
  logic [63:0] cycle_count, instr_retired;
`endif

  multicycle_cpu #(.DATA_WIDTH(64), .REG_COUNT(32), .RESET_PC(64'h0)) dut (
    .clock     (clock),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .pc_out    (pc_out),
    .halted    (halted)
`ifdef MULTICYCLE_CPU_PERF_COUNTERS_EN
    ,
    .cycle_count   (cycle_count),
    .instr_retired (instr_retired)
`endif
  );

  initial forever #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int waits  = 0;
  int cyc    = 0;

  logic [63:0] mem [logic [63:0]];
  logic [63:0] fetch_addr_q[$], st_addr_q[$], st_data_q[$];
  int          fetch_cyc_q[$];

  // architectural model
  logic [63:0] m_regs [32];
  logic [63:0] m_pc, m_daddr;
  logic [4:0]  m_t;
  bit          m_phase, m_store, m_halt, have_last;
  int          last_cyc, last_lat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rd(input logic [63:0] a);
    return mem.exists(a) ? mem[a] : 64'd0;
  endfunction

  function automatic logic [63:0] g(input logic [4:0] i);
    return (i == 5'd31) ? 64'd0 : m_regs[i];
  endfunction

  task automatic set_reg(input logic [4:0] i, input logic [63:0] v);
    if (i != 5'd31) m_regs[i] = v;
  endtask

  function automatic logic [31:0] r_ins(input logic [10:0] op, input logic [4:0] m, n, d);
    return {op, m, 6'b0, n, d};
  endfunction
  function automatic logic [31:0] d_ins(input logic [10:0] op, input logic [8:0] imm, input logic [4:0] n, t);
    return {op, imm, 2'b00, n, t};
  endfunction
  function automatic logic [31:0] cb_ins(input logic [18:0] imm, input logic [4:0] t);
    return {8'b10110100, imm, t};
  endfunction
  function automatic logic [31:0] b_ins(input logic [25:0] imm);
    return {6'b000101, imm};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
    m_pc = 64'd0; m_phase = 0; m_halt = 0; have_last = 0;
  endtask

  task automatic handshake();
    logic [63:0] w, off;
    logic [31:0] ins;
    if (m_halt) begin
      check("access_after_halt", {63'd0, mem_req}, 64'd0);
      return;
    end
    check("pc_out", pc_out, m_pc);
    if (!m_phase) begin
      check("fetch_addr", mem_addr, m_pc);
      check("fetch_we", {63'd0, mem_we}, 64'd0);
      if (have_last) check("latency", 64'(cyc - last_cyc), 64'(last_lat));
      have_last = 1;
      last_cyc = cyc;
      fetch_addr_q.push_back(mem_addr);
      fetch_cyc_q.push_back(cyc);
      w = rd(m_pc);
      ins = w[31:0];
      last_lat = 4 + waits;
      case (ins[31:21])
        T_ADD: begin set_reg(ins[4:0], g(ins[9:5]) + g(ins[20:16])); m_pc += 4; end
        T_SUB: begin set_reg(ins[4:0], g(ins[9:5]) - g(ins[20:16])); m_pc += 4; end
        T_AND: begin set_reg(ins[4:0], g(ins[9:5]) & g(ins[20:16])); m_pc += 4; end
        T_ORR: begin set_reg(ins[4:0], g(ins[9:5]) | g(ins[20:16])); m_pc += 4; end
        T_LDUR, T_STUR: begin
          m_daddr = g(ins[9:5]) + {{55{ins[20]}}, ins[20:12]};
          m_store = (ins[31:21] == T_STUR);
          m_t = ins[4:0];
          m_phase = 1;
          last_lat = (m_store ? 4 : 5) + 2 * waits;
        end
        default: begin
          if (ins[31:24] == 8'b10110100) begin
            off = {{43{ins[23]}}, ins[23:5], 2'b00};
            m_pc = (g(ins[4:0]) == 64'd0) ? m_pc + off : m_pc + 4;
            last_lat = 3 + waits;
          end else if (ins[31:26] == 6'b000101) begin
            off = {{36{ins[25]}}, ins[25:0], 2'b00};
            m_pc = m_pc + off;
            last_lat = 3 + waits;
          end else begin
            m_halt = 1;
          end
        end
      endcase
    end else begin
      check("data_addr", mem_addr, m_daddr);
      check("data_we", {63'd0, mem_we}, {63'd0, m_store});
      if (m_store) begin
        check("store_data", mem_wdata, g(m_t));
        mem[mem_addr] = mem_wdata;
        st_addr_q.push_back(mem_addr);
        st_data_q.push_back(mem_wdata);
      end else begin
        set_reg(m_t, rd(mem_addr));
      end
      m_pc += 4;
      m_phase = 0;
    end
  endtask

  // memory responder and per-cycle compare process
  initial begin
    int          wcnt;
    bit          prev_wait;
    logic [63:0] p_addr, p_wdata;
    logic        p_we;
    mem_ready = 1'b0; mem_rdata = 64'd0; wcnt = 0; prev_wait = 0;
    p_addr = 0; p_wdata = 0; p_we = 0;
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        mem_ready = 1'b0; wcnt = 0; prev_wait = 0;
        model_reset();
      end else begin
        mem_rdata = rd(mem_addr);
        if (prev_wait && mem_req) begin
          check("hold_addr", mem_addr, p_addr);
          check("hold_we", {63'd0, mem_we}, {63'd0, p_we});
          check("hold_wdata", mem_wdata, p_wdata);
        end
        if (mem_req && wcnt >= waits) begin
          mem_ready = 1'b1; wcnt = 0; prev_wait = 0;
          handshake();
        end else begin
          mem_ready = 1'b0;
          prev_wait = mem_req;
          p_addr = mem_addr; p_we = mem_we; p_wdata = mem_wdata;
          if (mem_req) wcnt++;
        end
      end
    end
  end

  task automatic clear_logs();
    fetch_addr_q.delete(); fetch_cyc_q.delete(); st_addr_q.delete(); st_data_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, {63'd0, mem_req}, 64'd0);
    check({tag, "_we"}, {63'd0, mem_we}, 64'd0);
    check({tag, "_addr"}, mem_addr, 64'd0);
    check({tag, "_wdata"}, mem_wdata, 64'd0);
    check({tag, "_pc"}, pc_out, 64'd0);
    check({tag, "_halted"}, {63'd0, halted}, 64'd0);
  endtask

  task automatic apply_reset(input int w);
    @(posedge clock); #2;
    reset = 1'b1;
    waits = w;
    repeat (2) @(posedge clock);
    #1 check_reset_outputs("reset");
    #1 clear_logs();
    reset = 1'b0;
  endtask

  task automatic wait_halt(input int bound, input logic [63:0] exp_pc);
    int n = 0;
    while (!halted && n < bound) begin
      @(posedge clock); #1;
      n++;
    end
    check("halt_reached", {63'd0, halted}, 64'd1);
    check("model_halted", {63'd0, m_halt}, 64'd1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      check("halt_hold", {63'd0, halted}, 64'd1);
      check("halt_req", {63'd0, mem_req}, 64'd0);
      check("halt_pc", pc_out, exp_pc);
    end
  endtask

  task automatic check_stores(input string tag, input int n, input logic [63:0] ea [4],
                              input logic [63:0] ed [4]);
    check({tag, "_store_count"}, 64'(st_addr_q.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (i < st_addr_q.size()) begin
        check({tag, "_store_addr"}, st_addr_q[i], ea[i]);
        check({tag, "_store_data"}, st_data_q[i], ed[i]);
      end
    end
  endtask

  task automatic load_b();
    mem.delete();
    mem[64'h00] = d_ins(T_STUR, 9'd176, 5'd31, 5'd0);
    mem[64'h04] = d_ins(T_LDUR, 9'd128, 5'd31, 5'd0);
    mem[64'h08] = d_ins(T_LDUR, 9'd136, 5'd31, 5'd1);
    mem[64'h0C] = d_ins(T_STUR, 9'd8, 5'd0, 5'd1);
    mem[64'h10] = d_ins(T_LDUR, 9'd8, 5'd0, 5'd4);
    mem[64'h14] = d_ins(T_STUR, 9'd144, 5'd31, 5'd4);
    mem[64'h80] = 64'h100;
    mem[64'h88] = 64'd12;
  endtask

  logic [63:0] exp_a [18] = '{64'h00, 64'h04, 64'h08, 64'h0C, 64'h10, 64'h14, 64'h18, 64'h1C,
                              64'h20, 64'h2C, 64'h40, 64'h38, 64'h3C, 64'h50, 64'h54, 64'h58,
                              64'h5C, 64'h60};

  initial begin
    logic [63:0] ea [4];
    logic [63:0] ed [4];
    int  n;
    bit  found;

    check("enc_add", {32'd0, r_ins(T_ADD, 5'd3, 5'd2, 5'd1)}, 64'h8B030041);
    check("enc_b", {32'd0, b_ins(26'h3FFFFFE)}, 64'h17FFFFFE);
    check("enc_cbz", {32'd0, cb_ins(19'd3, 5'd5)}, 64'hB4000065);

    // Program A: ALU ops, branches, XZR, halt; zero wait states
    mem.delete();
    mem[64'h00] = d_ins(T_LDUR, 9'd128, 5'd31, 5'd2);
    mem[64'h04] = d_ins(T_LDUR, 9'd136, 5'd31, 5'd3);
    mem[64'h08] = 32'h8B030041;
    mem[64'h0C] = d_ins(T_STUR, 9'd144, 5'd31, 5'd1);
    mem[64'h10] = r_ins(T_SUB, 5'd2, 5'd3, 5'd6);
    mem[64'h14] = r_ins(T_AND, 5'd3, 5'd2, 5'd7);
    mem[64'h18] = r_ins(T_ORR, 5'd3, 5'd2, 5'd8);
    mem[64'h1C] = d_ins(T_STUR, 9'd160, 5'd31, 5'd8);
    mem[64'h20] = 32'hB4000065;
    mem[64'h2C] = b_ins(26'd5);
    mem[64'h40] = 32'h17FFFFFE;
    mem[64'h38] = r_ins(T_ADD, 5'd3, 5'd2, 5'd31);
    mem[64'h3C] = b_ins(26'd5);
    mem[64'h50] = d_ins(T_STUR, 9'd152, 5'd31, 5'd31);
    mem[64'h54] = cb_ins(19'd3, 5'd2);
    mem[64'h58] = r_ins(T_SUB, 5'd3, 5'd2, 5'd9);
    mem[64'h5C] = d_ins(T_STUR, 9'd168, 5'd31, 5'd9);
    mem[64'h60] = 32'hFFFFFFFF;
    mem[64'h80] = 64'd5;
    mem[64'h88] = 64'd7;
    apply_reset(0);
    wait_halt(600, 64'h60);
    check("a_fetch_count", 64'(fetch_addr_q.size()), 64'd18);
    for (int i = 0; i < 18; i++)
      if (i < fetch_addr_q.size()) check("a_fetch_seq", fetch_addr_q[i], exp_a[i]);
    if (fetch_cyc_q.size() > 3)
      check("a_add_latency", 64'(fetch_cyc_q[3] - fetch_cyc_q[2]), 64'd4);
    ea = '{64'h90, 64'hA0, 64'h98, 64'hA8};
    ed = '{64'd12, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE};
    check_stores("a", 4, ea, ed);

    // Program B: store/load through X0=0x100 with two wait states per access
    load_b();
    apply_reset(2);
    wait_halt(800, 64'h18);
    if (fetch_cyc_q.size() > 5)
      check("b_load_latency", 64'(fetch_cyc_q[5] - fetch_cyc_q[4]), 64'd9);
    ea = '{64'hB0, 64'h108, 64'h90, 64'h0};
    ed = '{64'd0, 64'd12, 64'd12, 64'd0};
    check_stores("b", 3, ea, ed);

    // Program C: reset during a load's memory wait
    load_b();
    apply_reset(3);
    n = 0; found = 0;
    while (n < 300 && !found) begin
      @(posedge clock); #3;
      if (mem_req && !mem_we && mem_addr == 64'h88 && !mem_ready) found = 1;
      n++;
    end
    check("c_reached_wait", {63'd0, found}, 64'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    check_reset_outputs("c_midreset");
    waits = 1;
    load_b();
    #1 clear_logs();
    reset = 1'b0;
    wait_halt(800, 64'h18);
    if (fetch_addr_q.size() > 0) check("c_first_fetch", fetch_addr_q[0], 64'h0);
    ea = '{64'hB0, 64'h108, 64'h90, 64'h0};
    ed = '{64'd0, 64'd12, 64'd12, 64'd0};
    check_stores("c", 3, ea, ed);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required finish before it");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multicycle_cpu.md
Name: multicycle_cpu

Overview:
- Parametrised multi-cycle LEGv8 core; successor to the single-cycle CPU top.
- Executes one instruction over 3–5 states through a single unified memory port with a req/ready handshake, so memory may insert wait states.
- Sits between the clock/reset source and one shared instruction+data memory.

Parameters:
- DATA_WIDTH, 64, register/ALU/address width; must be ≥32 and a power of two.
- REG_COUNT, 32, architectural registers; the highest index is XZR.
- RESET_PC, 0, byte address fetched first after reset.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- mem_req  out  1  memory transaction request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  out  DATA_WIDTH  byte address.
- mem_wdata  out  DATA_WIDTH  store data.
- mem_rdata  in  DATA_WIDTH  read data; bits [31:0] carry the instruction on a fetch.
- mem_ready  in  1  transaction completes on a clock edge where mem_req=1 and mem_ready=1.
- pc_out  out  DATA_WIDTH  current PC.
- halted  out  1  core stopped on an undefined instruction.

Behaviour:
- Reset (synchronous, active-high), applied on any cycle including mid-transaction:
  - state=FETCH, pc=RESET_PC, IR=0, all registers=0, halted=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0 in the cycle after reset.
- States: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc. Stay until mem_ready=1. On that edge, IR←mem_rdata[31:0] → DECODE.
- DECODE: A←R[IR[9:5]], B←R[IR[20:16]] for R-type, else R[IR[4:0]]. Compute the sign-extended immediate. Unknown opcode → HALT.
- Decoded opcodes:
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 (IR[31:21]).
  - LDUR 11111000010, STUR 11111000000 (IR[31:21]).
  - CBZ 10110100 (IR[31:24]).
  - B 000101 (IR[31:26]).
- EXECUTE:
  - R-type: ALUOut←A op B → WRITEBACK.
  - LDUR/STUR: ALUOut←A + sext(IR[20:12]) → MEMORY.
  - CBZ: pc←(B==0) ? pc+(sext(IR[23:5])<<2) : pc+4 → FETCH.
  - B: pc←pc+(sext(IR[25:0])<<2) → FETCH.
- MEMORY: mem_req=1, mem_addr=ALUOut.
  - STUR: mem_we=1, mem_wdata=B. On ready, pc←pc+4 → FETCH.
  - LDUR: mem_we=0. On ready, MDR←mem_rdata → WRITEBACK.
- WRITEBACK: R[IR[4:0]]←(LDUR ? MDR : ALUOut), pc←pc+4 → FETCH.
- XZR (index REG_COUNT-1): reads return 0; writes are discarded.
- Arithmetic: all adds, including the PC, wrap modulo 2^DATA_WIDTH. No flags. No alignment checks.
- Outputs: mem_req/mem_we/mem_addr/mem_wdata are registered, driven from state, and held stable while waiting for ready.
- Latency with zero wait states (FETCH through next FETCH): R-type 4, LDUR 5, STUR 4, CBZ/B 3. Each wait state adds one cycle.
- HALT: mem_req=0, halted=1, pc frozen. Only reset exits HALT.
- mem_ready while mem_req=0: ignored.

Optional Feature:
- Macro MULTICYCLE_CPU_PERF_COUNTERS_EN.
- Defined: adds outputs cycle_count (DATA_WIDTH) and instr_retired (DATA_WIDTH).
  - cycle_count increments every non-reset, non-HALT cycle.
  - instr_retired increments on each transition into FETCH from EXECUTE, MEMORY or WRITEBACK.
  - Both clear on reset and wrap.
- Undefined: neither port nor counter logic exists; all other behaviour is identical.

Decomposition:
- Package legv8_pkg:
  - opcode constants (R-type, LDUR/STUR, CBZ, B);
  - state enum;
  - ALU operation codes;
  - XZR index function of REG_COUNT.
- Sub-module multicycle_register_file (clock, reset, 2 read ports, 1 write port, XZR hardwired).
- ALU and sign-extend are inline in multicycle_cpu.

Test Plan:
- ADD X1,X2,X3 with X2=5, X3=7, mem_ready tied 1 → X1=12 after 4 cycles; pc advances 0→4.
- STUR X1,[X0,#8] then LDUR X4,[X0,#8], X0=0x100, 2 wait states per access → write at 0x108 data 12; X4=12; load takes 5+2+2 cycles.
- CBZ X5,#3 with X5=0 at pc=0x20 → next fetch at 0x2C. With X5=1 → next fetch at 0x24.
- B #-2 at pc=0x40 → next fetch at 0x38. ADD X31,X2,X3 → subsequent read of X31 returns 0.
- IR=0xFFFFFFFF → halted=1 after DECODE; mem_req stays 0; pc frozen for 20 cycles.
- Reset asserted during a LDUR MEMORY wait → next cycle mem_req=0; then fetch at RESET_PC; registers read 0.
